move_input_ctrl: RTL and testbench
==================================

Name: move_input_ctrl

Overview:
- Producer side of the 2048 game controller's direction interface.
- Turns four raw, bouncy push-buttons into clean single-cycle, one-hot up/down/left/right move commands.
- Holds at most one pending move and releases it only when the game FSM signals it is waiting (ready, driven from q_Wait).
- Sits between the board-level button pins and the game state machine.

Parameters:
- DEBOUNCE_CYCLES, 1000000, N: consecutive stable synced samples needed to confirm a press or a release (≥1).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived; do not override).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- btnU  in  1  raw up button; asynchronous to Clk, active high.
- btnD  in  1  raw down button.
- btnL  in  1  raw left button.
- btnR  in  1  raw right button.
- ready  in  1  consumer is in WAIT and will sample a move this cycle.
- up  out  1  one-cycle move-up command.
- down  out  1  one-cycle move-down command.
- left  out  1  one-cycle move-left command.
- right  out  1  one-cycle move-right command.
- pending  out  1  a confirmed move is held, not yet issued.
- dropped  out  1  one-cycle pulse: a confirmed press was discarded.

Behaviour:
- Reset (async, active-high): all outputs 0, pending register empty, every debouncer in IDLE with counter 0, synchronizers 0.
- Per button: a 2-flop synchronizer, then a debounce FSM with states IDLE, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE.
- IDLE: synced high → CONFIRM_PRESS, cnt=0.
- CONFIRM_PRESS:
  - synced low → IDLE, no event.
  - high with cnt==N-1 → PRESSED and assert press_evt for exactly 1 cycle (registered).
  - otherwise cnt++.
- PRESSED: synced low → CONFIRM_RELEASE, cnt=0.
- CONFIRM_RELEASE: synced high → PRESSED; low with cnt==N-1 → IDLE; otherwise cnt++. Release emits no event.
- Consequence: one event per physical press; holding a button never repeats.
- Latency: raw input stable high from before edge 0 gives press_evt high after edge N+2. The move is captured into pending after edge N+3. With ready=1, the output pulse is high for the cycle after edge N+4.
- Capture, in the cycle press_evt is seen:
  - If one or more press_evts are high, the highest priority is selected: U > D > L > R.
  - If the holding register is free (empty, or being issued this same cycle), the selected move is stored and pending=1 next cycle.
  - Every press_evt not stored (lower priority, or register occupied and not issuing) asserts dropped for 1 cycle. A single dropped pulse covers any number of discards in that cycle.
- Issue:
  - If pending=1 and ready=1, exactly one of up/down/left/right is asserted next cycle, for exactly 1 cycle, and pending clears.
  - No combinational bypass: an event never issues in the same cycle it is captured.
  - If ready is low, the move is held indefinitely; the outputs stay 0.
- Outputs are registered and mutually exclusive; at most one direction is high in any cycle.
- Reset mid-debounce or while pending: the move is discarded with no output. A button still held after Reset deasserts is treated as a new press and yields an event after full debounce.
- N=1 is legal: a press is confirmed after 1 stable sample in CONFIRM_PRESS.

Decomposition:
- Package ee354_2048_pkg holds:
  - 2-bit direction encoding: DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3.
  - Debounce state localparams.
- One sub-module, btn_debounce (synchronizer + FSM + counter, parameter DEBOUNCE_CYCLES; ports Clk, Reset, raw, press_evt), instantiated four times.
- Priority select, holding register and output pulse logic live in move_input_ctrl.

Test Plan (DEBOUNCE_CYCLES=4):
- btnL held high, ready=1 → left=1 for one cycle after edge 8, pending=1 for exactly that one preceding cycle, no repeat while held for 100 cycles; release then re-press → second left pulse.
- btnU toggling every 2 cycles for 20 cycles, then low → no output, dropped=0; then stable high → exactly one up pulse.
- btnD and btnR rise on the same edge, ready=1 → single down pulse; dropped=1 once, in the capture cycle.
- ready=0; press R, release, then press U → pending=1 and R held; U confirm gives dropped pulse; ready=1 → right pulse only, pending=0.
- btnU held, Reset asserted 2 cycles after pending=1 → outputs and pending 0 immediately; after Reset release, up pulse appears N+5 edges later with ready=1.

Source files
------------

// File: rtl/ee354_2048_pkg.sv
// Shared encodings for the 2048 controller: move directions and debounce FSM states.
package ee354_2048_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    DB_IDLE            = 2'd0,
    DB_CONFIRM_PRESS   = 2'd1,
    DB_PRESSED         = 2'd2,
    DB_CONFIRM_RELEASE = 2'd3
  } db_state_e;

endpackage

// File: rtl/move_input_ctrl_btn_debounce.sv
// One push-button: 2-flop synchronizer followed by a press/release debounce FSM
// that emits a single registered press_evt per confirmed press.
module btn_debounce
  import ee354_2048_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic raw,
  output logic press_evt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  db_state_e        state_q;
  db_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             evt_d;

  // Stage p0/p1: metastability synchronizer, then FSM state and event register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_p0   <= 1'b0;
      sync_p1   <= 1'b0;
      state_q   <= DB_IDLE;
      cnt_q     <= '0;
      press_evt <= 1'b0;
    end else begin
      sync_p0   <= raw;
      sync_p1   <= sync_p0;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_evt <= evt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    evt_d   = 1'b0;
    unique case (state_q)
      DB_IDLE: begin
        if (sync_p1) begin
          state_d = DB_CONFIRM_PRESS;
          cnt_d   = '0;
        end
      end
      DB_CONFIRM_PRESS: begin
        if (!sync_p1) begin
          state_d = DB_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_PRESSED;
          evt_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DB_PRESSED: begin
        if (!sync_p1) begin
          state_d = DB_CONFIRM_RELEASE;
          cnt_d   = '0;
        end
      end
      DB_CONFIRM_RELEASE: begin
        if (sync_p1) begin
          state_d = DB_PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = DB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/move_input_ctrl.sv
// Direction producer for the 2048 game FSM: debounced buttons feed a one-deep
// move holding register that is released as a one-hot pulse when ready is high.
module move_input_ctrl
  import ee354_2048_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btnU,
  input  logic btnD,
  input  logic btnL,
  input  logic btnR,
  input  logic ready,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic pending,
  output logic dropped
);

  logic [3:0] evt_p0;
  logic       pending_p1;
  logic [1:0] dir_p1;
  logic [3:0] move_p2;
  logic       dropped_p2;

  logic       any_evt;
  logic [1:0] sel_dir;
  logic       slot_free;
  logic       store;
  logic       pending_d;
  logic [1:0] dir_d;
  logic [3:0] move_d;
  logic       dropped_d;

  function automatic logic [1:0] prio_dir(input logic [3:0] e);
    if (e[DIR_UP])        return DIR_UP;
    else if (e[DIR_DOWN]) return DIR_DOWN;
    else if (e[DIR_LEFT]) return DIR_LEFT;
    else                  return DIR_RIGHT;
  endfunction

  function automatic logic [3:0] dir_onehot(input logic [1:0] d);
    return 4'b0001 << d;
  endfunction

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .Clk(Clk), .Reset(Reset), .raw(btnU), .press_evt(evt_p0[DIR_UP])
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .Clk(Clk), .Reset(Reset), .raw(btnD), .press_evt(evt_p0[DIR_DOWN])
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .Clk(Clk), .Reset(Reset), .raw(btnL), .press_evt(evt_p0[DIR_LEFT])
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .Clk(Clk), .Reset(Reset), .raw(btnR), .press_evt(evt_p0[DIR_RIGHT])
  );

  // A slot being issued this cycle may be refilled in the same cycle
  always_comb begin
    any_evt   = |evt_p0;
    sel_dir   = prio_dir(evt_p0);
    slot_free = !pending_p1 || ready;
    store     = any_evt && slot_free;
    dropped_d = any_evt && (!slot_free || ((evt_p0 & ~dir_onehot(sel_dir)) != 4'b0000));
    pending_d = store || (pending_p1 && !ready);
    dir_d     = store ? sel_dir : dir_p1;
    move_d    = (pending_p1 && ready) ? dir_onehot(dir_p1) : 4'b0000;
  end

  // Stage p1/p2: holding register and registered output pulses
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pending_p1 <= 1'b0;
      move_p2    <= 4'b0000;
      dropped_p2 <= 1'b0;
    end else begin
      pending_p1 <= pending_d;
      move_p2    <= move_d;
      dropped_p2 <= dropped_d;
    end
  end

  always_ff @(posedge Clk) begin
    dir_p1 <= dir_d;
  end

  assign up      = move_p2[DIR_UP];
  assign down    = move_p2[DIR_DOWN];
  assign left    = move_p2[DIR_LEFT];
  assign right   = move_p2[DIR_RIGHT];
  assign pending = pending_p1;
  assign dropped = dropped_p2;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Directed bench for move_input_ctrl with a 4-cycle debounce.
module tb_move_input_ctrl;

  logic Clk;
  logic Reset;
  logic btnU, btnD, btnL, btnR;
  logic ready;
  logic up, down, left, right, pending, dropped;

  int checks = 0;
  int errors = 0;
  int up_cnt = 0, down_cnt = 0, left_cnt = 0, right_cnt = 0, drop_cnt = 0;
  int up_b, down_b, left_b, right_b, drop_b;
  int wait_n;
  bit seen;

  move_input_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
    .ready(ready),
    .up(up), .down(down), .left(left), .right(right),
    .pending(pending), .dropped(dropped)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(negedge Clk) begin
    if (up)      up_cnt++;
    if (down)    down_cnt++;
    if (left)    left_cnt++;
    if (right)   right_cnt++;
    if (dropped) drop_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    up_b = up_cnt; down_b = down_cnt; left_b = left_cnt;
    right_b = right_cnt; drop_b = drop_cnt;
  endtask

  initial begin
    Reset = 1'b1; ready = 1'b0;
    btnU = 1'b0; btnD = 1'b0; btnL = 1'b0; btnR = 1'b0;
    tick(2);
    chk("reset_outputs", int'({up, down, left, right}), 0);
    chk("reset_pending", int'(pending), 0);
    chk("reset_dropped", int'(dropped), 0);
    Reset = 1'b0;
    tick(3);

    // Left held: event after edge 6, pending after edge 7, pulse after edge 8
    ready = 1'b1;
    snap();
    btnL = 1'b1;
    tick(7);
    chk("L_pending_e6", int'(pending), 0);
    tick(1);
    chk("L_pending_e7", int'(pending), 1);
    chk("L_left_e7", int'(left), 0);
    tick(1);
    chk("L_left_e8", int'(left), 1);
    chk("L_pending_e8", int'(pending), 0);
    chk("L_onehot_e8", int'({up, down, right}), 0);
    tick(1);
    chk("L_left_e9", int'(left), 0);
    tick(100);
    chk("L_no_repeat", left_cnt - left_b, 1);
    chk("L_no_drop", drop_cnt - drop_b, 0);
    btnL = 1'b0;
    tick(10);
    btnL = 1'b1;
    tick(12);
    chk("L_repress", left_cnt - left_b, 2);
    btnL = 1'b0;
    tick(10);

    // Bouncing up button never confirms
    snap();
    for (int i = 0; i < 10; i++) begin
      btnU = ~btnU;
      tick(2);
    end
    btnU = 1'b0;
    tick(10);
    chk("U_bounce_up", up_cnt - up_b, 0);
    chk("U_bounce_drop", drop_cnt - drop_b, 0);
    chk("U_bounce_pending", int'(pending), 0);
    btnU = 1'b1;
    tick(12);
    chk("U_stable_up", up_cnt - up_b, 1);
    btnU = 1'b0;
    tick(10);

    // Down and right together: down wins, right is dropped
    snap();
    btnD = 1'b1; btnR = 1'b1;
    tick(8);
    chk("DR_pending", int'(pending), 1);
    chk("DR_dropped", int'(dropped), 1);
    tick(1);
    chk("DR_down", int'(down), 1);
    chk("DR_dropped_clear", int'(dropped), 0);
    tick(10);
    chk("DR_down_cnt", down_cnt - down_b, 1);
    chk("DR_right_cnt", right_cnt - right_b, 0);
    chk("DR_drop_cnt", drop_cnt - drop_b, 1);
    btnD = 1'b0; btnR = 1'b0;
    tick(10);

    // Held right while not ready; later up press is dropped
    ready = 1'b0;
    snap();
    btnR = 1'b1;
    tick(8);
    chk("RU_pending_R", int'(pending), 1);
    btnR = 1'b0;
    tick(10);
    btnU = 1'b1;
    tick(8);
    chk("RU_dropped", int'(dropped), 1);
    chk("RU_pending_hold", int'(pending), 1);
    tick(20);
    chk("RU_no_output", (right_cnt - right_b) + (up_cnt - up_b), 0);
    chk("RU_drop_cnt", drop_cnt - drop_b, 1);
    ready = 1'b1;
    tick(1);
    chk("RU_right", int'(right), 1);
    chk("RU_pending_clr", int'(pending), 0);
    tick(5);
    chk("RU_right_cnt", right_cnt - right_b, 1);
    chk("RU_up_cnt", up_cnt - up_b, 0);
    btnU = 1'b0;
    tick(10);

    // Reset while a move is pending, button still held afterwards
    ready = 1'b0;
    btnU = 1'b1;
    tick(8);
    chk("RST_pending_before", int'(pending), 1);
    tick(2);
    Reset = 1'b1;
    #1;
    chk("RST_pending_async", int'(pending), 0);
    chk("RST_outputs_async", int'({up, down, left, right, dropped}), 0);
    tick(2);
    ready = 1'b1;
    Reset = 1'b0;
    wait_n = 0;
    seen = 1'b0;
    while (!seen && wait_n < 30) begin
      tick(1);
      wait_n++;
      if (up) seen = 1'b1;
    end
    chk("RST_up_seen", int'(seen), 1);
    chk("RST_up_latency", wait_n, 9);
    tick(1);
    chk("RST_up_single", int'(up), 0);
    btnU = 1'b0;
    tick(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
